imuldiv_muldiv_iter_tagged: RTL and testbench

Parametrised iterative multiply/divide unit with tagged requests, serving as the long-latency functional unit behind the out-of-order issue stage. Accepts one signed/unsigned mul, div or rem operation at a time over a val/rdy request port, computes it over W iterations, and returns a 2W-bit result with the request tag. A kill input squashes the in-flight operation on mispredict or flush.

---
 rtl/imuldiv_muldiv_iter_tagged.sv | 151 +++++++++++++++
 tb/tb_imuldiv_muldiv_iter_tagged.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/imuldiv_muldiv_iter_tagged.sv
// Iterative radix-2 multiply/divide unit with tagged val/rdy request and response ports.
// Optional build macro IMULDIV_EARLY_TERM_EN: mul stops once the remaining multiplier bits are zero.
module imuldiv_muldiv_iter_tagged #(
  parameter int W    = 32,
  parameter int TAGW = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              kill_i,
  input  logic              req_val_i,
  output logic              req_rdy_o,
  input  logic [2:0]        req_fn_i,
  input  logic [W-1:0]      req_a_i,
  input  logic [W-1:0]      req_b_i,
  input  logic [TAGW-1:0]   req_tag_i,
  output logic              resp_val_o,
  input  logic              resp_rdy_i,
  output logic [2*W-1:0]    resp_result_o,
  output logic [TAGW-1:0]   resp_tag_o
);

  localparam int            CW       = $clog2(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
  localparam logic [2:0]    FN_MUL   = 3'd0;
  localparam logic [2:0]    FN_DIV   = 3'd1;
  localparam logic [2:0]    FN_DIVU  = 3'd2;
  localparam logic [2:0]    FN_REM   = 3'd3;
  localparam logic [2:0]    FN_REMU  = 3'd4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      fn_q;
  logic [TAGW-1:0] tag_q;
  logic [2*W-1:0]  acc_q;
  logic [2*W-1:0]  mcand_q;
  logic [W-1:0]    mplr_q;
  logic            neg_q;
  logic            rneg_q;
  logic            div0_q;
  logic [2*W-1:0]  result_q;
  logic [TAGW-1:0] rtag_q;

  logic            req_signed, req_is_mul, req_is_div, a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;

  assign req_is_mul = (req_fn_i == FN_MUL);
  assign req_is_div = req_fn_i inside {FN_DIV, FN_DIVU, FN_REM, FN_REMU};
  assign req_signed = req_fn_i inside {FN_MUL, FN_DIV, FN_REM};
  assign a_neg      = req_signed & req_a_i[W-1];
  assign b_neg      = req_signed & req_b_i[W-1];
  assign a_mag      = a_neg ? -req_a_i : req_a_i;
  assign b_mag      = b_neg ? -req_b_i : req_b_i;

  logic            is_mul, is_div, last_step;
  logic [2*W-1:0]  mul_sum, acc_step, final_res;
  logic [W:0]      partial, diff;
  logic [W-1:0]    rem_step, quo_step;

  assign is_mul = (fn_q == FN_MUL);
  assign is_div = fn_q inside {FN_DIV, FN_DIVU, FN_REM, FN_REMU};

  // acc_q holds the running product for mul, {remainder, quotient/dividend} for div.
  always_comb begin
    mul_sum = acc_q + (mplr_q[0] ? mcand_q : '0);
    partial = {acc_q[2*W-1:W], acc_q[W-1]};
    diff    = partial - {1'b0, mplr_q};
    if (diff[W]) begin
      rem_step = partial[W-1:0];
      quo_step = {acc_q[W-2:0], 1'b0};
    end else begin
      rem_step = diff[W-1:0];
      quo_step = {acc_q[W-2:0], 1'b1};
    end
    acc_step  = is_mul ? mul_sum : {rem_step, quo_step};
    last_step = (cnt_q == LAST_CNT);
`ifdef IMULDIV_EARLY_TERM_EN
    if (is_mul && (mplr_q[W-1:1] == '0)) last_step = 1'b1;
`endif
    final_res = '0;
    if (is_mul) begin
      final_res = neg_q ? -mul_sum : mul_sum;
    end else if (is_div) begin
      if (div0_q) final_res = {mcand_q[W-1:0], {W{1'b1}}};
      else        final_res = {rneg_q ? -rem_step : rem_step, neg_q ? -quo_step : quo_step};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fn_q     <= '0;
      tag_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      rtag_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_val_i && !kill_i) begin
            fn_q    <= req_fn_i;
            tag_q   <= req_tag_i;
            cnt_q   <= '0;
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            div0_q  <= req_is_div && (req_b_i == '0);
            mplr_q  <= b_mag;
            // Divides keep the raw dividend here for the divide-by-zero remainder.
            mcand_q <= {{W{1'b0}}, req_is_mul ? a_mag : req_a_i};
            acc_q   <= req_is_mul ? '0 : {{W{1'b0}}, a_mag};
            state_q <= CALC;
          end
        end
        CALC: begin
          if (kill_i) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
            if (is_mul) begin
              mcand_q <= mcand_q << 1;
              mplr_q  <= mplr_q >> 1;
            end
            if (last_step) begin
              result_q <= final_res;
              rtag_q   <= tag_q;
              state_q  <= DONE;
            end
          end
        end
        DONE: begin
          if (kill_i || resp_rdy_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_rdy_o     = (state_q == IDLE);
  assign resp_val_o    = (state_q == DONE);
  assign resp_result_o = result_q;
  assign resp_tag_o    = rtag_q;

endmodule

// File: tb/tb_imuldiv_muldiv_iter_tagged.sv
// Directed bench for imuldiv_muldiv_iter_tagged (W=32): results, latency, back-pressure, kill, reset.
module tb_imuldiv_muldiv_iter_tagged;

  localparam int W    = 32;
  localparam int TAGW = 4;

  logic            clk = 1'b0;
  logic            reset, kill, req_val, req_rdy, resp_val, resp_rdy;
  logic [2:0]      req_fn;
  logic [W-1:0]    req_a, req_b;
  logic [TAGW-1:0] req_tag, resp_tag;
  logic [2*W-1:0]  resp_result;

  int tests = 0;
  int fails = 0;

  imuldiv_muldiv_iter_tagged #(.W(W), .TAGW(TAGW)) dut (
    .clk_i(clk), .reset_i(reset), .kill_i(kill),
    .req_val_i(req_val), .req_rdy_o(req_rdy), .req_fn_i(req_fn),
    .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
    .resp_val_o(resp_val), .resp_rdy_i(resp_rdy),
    .resp_result_o(resp_result), .resp_tag_o(resp_tag)
  );

  always #5 clk = ~clk;

  // Issues one request from an idle DUT; returns the first response and the cycles after acceptance.
  task automatic run_op(input logic [2:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TAGW-1:0] tag, output logic [2*W-1:0] res,
                        output logic [TAGW-1:0] rtag, output int lat, output bit ok);
    req_fn = fn; req_a = a; req_b = b; req_tag = tag; req_val = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    lat = 0;
    while (!resp_val && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    ok   = resp_val;
    res  = resp_result;
    rtag = resp_tag;
    $display("[TB] op fn=%0d a=%h b=%h tag=%0d -> result=%h tag=%0d after %0d cycles",
             fn, a, b, tag, res, rtag, lat);
  endtask

  task automatic test_reset();
    tests++; if (req_rdy !== 1'b1) begin fails++; $display("FAIL reset_req_rdy got %b want 1", req_rdy); end
    tests++; if (resp_val !== 1'b0) begin fails++; $display("FAIL reset_resp_val got %b want 0", resp_val); end
    tests++; if (resp_result !== '0) begin fails++; $display("FAIL reset_result got %h want 0", resp_result); end
    tests++; if (resp_tag !== '0) begin fails++; $display("FAIL reset_tag got %h want 0", resp_tag); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [2*W-1:0]  res;
    logic [TAGW-1:0] rtag;
    int              lat, exp_lat;
    bit              ok;
    logic [W-1:0]    ma [3] = '{32'h8000_0000, 32'h1234_5678, 32'h0000_0000};
    logic [W-1:0]    mb [3] = '{32'h8000_0000, 32'hffff_ffff, 32'h1234_5678};
    logic [2*W-1:0]  me [3] = '{64'h4000_0000_0000_0000, 64'hffff_ffff_edcb_a988, 64'h0};
`ifdef IMULDIV_EARLY_TERM_EN
    exp_lat = 4;
`else
    exp_lat = W;
`endif
    resp_rdy = 1'b1;
    run_op(3'd0, 32'hffff_fff8, 32'h0000_0008, 4'd3, res, rtag, lat, ok);
    tests++; if (!ok) begin fails++; $display("FAIL mul_timeout no resp_val within %0d cycles", lat); end
    tests++; if (res !== 64'hffff_ffff_ffff_ffc0) begin fails++; $display("FAIL mul_neg got %h want ffffffffffffffc0", res); end
    tests++; if (rtag !== 4'd3) begin fails++; $display("FAIL mul_tag got %0d want 3", rtag); end
    tests++; if (lat !== exp_lat) begin fails++; $display("FAIL mul_latency got %0d want %0d", lat, exp_lat); end
    @(posedge clk); #1;
    tests++; if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
      fails++; $display("FAIL mul_consume got val=%b rdy=%b want val=0 rdy=1", resp_val, req_rdy); end
    for (int i = 0; i < 3; i++) begin
      run_op(3'd0, ma[i], mb[i], 4'(i + 8), res, rtag, lat, ok);
      tests++; if (!ok || res !== me[i] || rtag !== 4'(i + 8)) begin
        fails++; $display("FAIL mul_vec%0d got %h tag %0d want %h tag %0d", i, res, rtag, me[i], i + 8); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_divrem();
    logic [2*W-1:0]  res;
    logic [TAGW-1:0] rtag;
    int              lat;
    bit              ok;
    logic [2:0]      dfn [9] = '{3'd3, 3'd4, 3'd1, 3'd1, 3'd2, 3'd1, 3'd3, 3'd1, 3'd5};
    logic [W-1:0]    da  [9] = '{32'hdead_beef, 32'hf5fe_4fbc, 32'h0000_0007, 32'h8000_0000,
                                 32'h0000_0064, 32'hffff_fff9, 32'h0000_0007, 32'hffff_fff9,
                                 32'h0000_1234};
    logic [W-1:0]    db  [9] = '{32'h0000_beef, 32'hffff_b14a, 32'h0000_0000, 32'hffff_ffff,
                                 32'h0000_0007, 32'h0000_0002, 32'hffff_fffe, 32'h0000_0000,
                                 32'h0000_0005};
    logic [2*W-1:0]  de  [9] = '{64'hffff_da72_ffff_d353, 64'hf5fe_4fbc_0000_0000,
                                 64'h0000_0007_ffff_ffff, 64'h0000_0000_8000_0000,
                                 64'h0000_0002_0000_000e, 64'hffff_ffff_ffff_fffd,
                                 64'h0000_0001_ffff_fffd, 64'hffff_fff9_ffff_ffff,
                                 64'h0000_0000_0000_0000};
    resp_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run_op(dfn[i], da[i], db[i], 4'(i), res, rtag, lat, ok);
      tests++; if (!ok || res !== de[i] || rtag !== 4'(i)) begin
        fails++; $display("FAIL div_vec%0d got %h tag %0d want %h tag %0d", i, res, rtag, de[i], i); end
      tests++; if (lat !== W) begin fails++; $display("FAIL div_latency%0d got %0d want %0d", i, lat, W); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_pressure();
    logic [2*W-1:0]  res;
    logic [TAGW-1:0] rtag;
    int              lat;
    bit              ok;
    resp_rdy = 1'b0;
    run_op(3'd0, 32'd6, 32'd7, 4'd9, res, rtag, lat, ok);
    tests++; if (!ok || res !== 64'h2a) begin fails++; $display("FAIL bp_first got %h want 2a", res); end
    req_fn = 3'd2; req_a = 32'd100; req_b = 32'd7; req_tag = 4'd2; req_val = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++; if ({resp_val, req_rdy, resp_tag, resp_result} !== {1'b1, 1'b0, 4'd9, 64'h2a}) begin
        fails++; $display("FAIL bp_hold%0d got val=%b rdy=%b tag=%0d res=%h want val=1 rdy=0 tag=9 res=2a",
                          i, resp_val, req_rdy, resp_tag, resp_result); end
    end
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    tests++; if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
      fails++; $display("FAIL bp_release got val=%b rdy=%b want val=0 rdy=1", resp_val, req_rdy); end
    @(posedge clk); #1;
    req_val = 1'b0;
    tests++; if (req_rdy !== 1'b0) begin fails++; $display("FAIL bp_accept got rdy=%b want 0", req_rdy); end
    lat = 0;
    while (!resp_val && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("[TB] op fn=2 a=%h b=%h tag=2 -> result=%h tag=%0d after %0d cycles",
             32'd100, 32'd7, resp_result, resp_tag, lat);
    tests++; if (resp_result !== 64'h0000_0002_0000_000e || resp_tag !== 4'd2 || lat !== W) begin
      fails++; $display("FAIL bp_second got %h tag %0d lat %0d want 000000020000000e tag 2 lat %0d",
                        resp_result, resp_tag, lat, W); end
    @(posedge clk); #1;
  endtask

  task automatic test_kill();
    logic [2*W-1:0]  res;
    logic [TAGW-1:0] rtag;
    int              lat, stray;
    bit              ok;
    resp_rdy = 1'b1;
    req_fn = 3'd0; req_a = 32'h1234; req_b = 32'h5678; req_tag = 4'd5; req_val = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    repeat (4) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    tests++; if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
      fails++; $display("FAIL kill_calc got rdy=%b val=%b want rdy=1 val=0", req_rdy, resp_val); end
    run_op(3'd0, 32'd3, 32'd8, 4'd7, res, rtag, lat, ok);
    tests++; if (!ok || res !== 64'h18 || rtag !== 4'd7 || lat !== W) begin
      fails++; $display("FAIL kill_next got %h tag %0d lat %0d want 18 tag 7 lat %0d", res, rtag, lat, W); end
    @(posedge clk); #1;
    req_val = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0; kill = 1'b0;
    tests++; if (req_rdy !== 1'b1) begin fails++; $display("FAIL kill_blocks_accept got rdy=%b want 1", req_rdy); end
    resp_rdy = 1'b0;
    run_op(3'd0, 32'd2, 32'd2, 4'd1, res, rtag, lat, ok);
    kill = 1'b1; resp_rdy = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    tests++; if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
      fails++; $display("FAIL kill_done got val=%b rdy=%b want val=0 rdy=1", resp_val, req_rdy); end
    stray = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (resp_val) stray++;
    end
    tests++; if (stray !== 0) begin fails++; $display("FAIL kill_no_resp got %0d response cycles want 0", stray); end
  endtask

  task automatic test_async_reset();
    logic [2*W-1:0]  res;
    logic [TAGW-1:0] rtag;
    int              lat;
    bit              ok;
    resp_rdy = 1'b1;
    req_fn = 3'd1; req_a = 32'd1000; req_b = 32'd3; req_tag = 4'd6; req_val = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    tests++; if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
      fails++; $display("FAIL areset_calc got val=%b rdy=%b want val=0 rdy=1", resp_val, req_rdy); end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    run_op(3'd0, 32'd3, 32'd8, 4'd7, res, rtag, lat, ok);
    tests++; if (!ok || res !== 64'h18) begin fails++; $display("FAIL areset_pre got %h want 18", res); end
    #2 reset = 1'b1;
    #1;
    tests++; if ({resp_val, req_rdy, resp_tag, resp_result} !== {1'b0, 1'b1, 4'd0, 64'd0}) begin
      fails++; $display("FAIL areset_done got val=%b rdy=%b tag=%0d res=%h want val=0 rdy=1 tag=0 res=0",
                        resp_val, req_rdy, resp_tag, resp_result); end
    @(negedge clk) reset = 1'b0;
    resp_rdy = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; kill = 1'b0; req_val = 1'b0; resp_rdy = 1'b1;
    req_fn = '0; req_a = '0; req_b = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_mul();
    test_divrem();
    test_back_pressure();
    test_kill();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
